// File: rtl/ddr_pkg.sv
// Shared types and widths for the lane hit judge: FSM states, lives/multiplier widths, lane index.
package ddr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    OVER = 2'd2
  } judge_state_t;

  localparam int LIVES_W       = 3;
  localparam int MULT_W        = 4;
  localparam int NUM_LANES_DEF = 4;

  typedef logic [$clog2(NUM_LANES_DEF)-1:0] lane_idx_t;

endpackage

// File: rtl/lane_hit_judge_if.sv
// Game-side bus of the lane hit judge: beat/tick/button inputs and score/lives outputs.
interface lane_hit_judge_if
  import ddr_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int SCORE_W   = 14,
  parameter int COMBO_W   = 14
) ();

  logic                 tick;
  logic                 beat;
  logic [NUM_LANES-1:0] arrow_mask;
  logic [NUM_LANES-1:0] btn;
  logic                 pause;
  logic [SCORE_W-1:0]   score;
  logic [COMBO_W-1:0]   combo;
  logic [MULT_W-1:0]    multiplier;
  logic [LIVES_W-1:0]   lives;
  logic                 correct_hit;
  logic                 incorrect_hit;
  logic                 game_over;

  modport master (
    output tick, beat, arrow_mask, btn, pause,
    input  score, combo, multiplier, lives, correct_hit, incorrect_hit, game_over
  );

  modport slave (
    input  tick, beat, arrow_mask, btn, pause,
    output score, combo, multiplier, lives, correct_hit, incorrect_hit, game_over
  );

endinterface

// File: rtl/lane_hit_judge_btn_edge_detect.sv
// Per-lane rising-edge detector with a registered pulse output; i_hold discards edges.
module btn_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_level,
  input  logic             i_hold,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_level_q;
  logic [WIDTH-1:0] r_rise;

  // Level history tracks the buttons even while held, so releasing hold never shows a phantom edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_level_q <= i_level;
      r_rise    <= '0;
    end else begin
      r_level_q <= i_level;
      r_rise    <= i_hold ? '0 : (i_level & ~r_level_q);
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/lane_hit_judge.sv
// Multi-lane hit judge: per-beat window timing, score/combo/multiplier/lives, game-over.
// Optional LANE_HIT_JUDGE_LIFE_REGEN_EN: regain one life every REGEN_COMBO consecutive hits.
module lane_hit_judge
  import ddr_pkg::*;
#(
  parameter int NUM_LANES      = NUM_LANES_DEF,
  parameter int WINDOW_TICKS   = 8,
  parameter int PERFECT_TICKS  = 3,
  parameter int POINTS_PERFECT = 3,
  parameter int POINTS_GOOD    = 1,
  parameter int COMBO_PER_MULT = 10,
  parameter int MULT_MAX       = 8,
  parameter int LIVES_INIT     = 5,
  parameter int SCORE_W        = 14,
  parameter int COMBO_W        = 14
`ifdef LANE_HIT_JUDGE_LIFE_REGEN_EN
  , parameter int REGEN_COMBO  = 25
`endif
) (
  input logic             clk,
  input logic             reset,
  lane_hit_judge_if.slave bus
);

  localparam int WIN_W = $clog2(WINDOW_TICKS + 1);
  localparam int SUB_W = $clog2(COMBO_PER_MULT + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(WINDOW_TICKS);
  localparam logic [WIN_W-1:0]   WIN_PERFECT = WIN_W'(PERFECT_TICKS);
  localparam logic [SUB_W-1:0]   SUB_LAST    = SUB_W'(COMBO_PER_MULT - 1);
  localparam logic [MULT_W-1:0]  MULT_TOP    = MULT_W'(MULT_MAX);
  localparam logic [LIVES_W-1:0] LIVES_FULL  = LIVES_W'(LIVES_INIT);
  localparam logic [SCORE_W:0]   PTS_PERFECT = (SCORE_W+1)'(POINTS_PERFECT);
  localparam logic [SCORE_W:0]   PTS_GOOD    = (SCORE_W+1)'(POINTS_GOOD);

  judge_state_t         r_state, w_state_nx;
  logic [NUM_LANES-1:0] r_pending, w_pending_nx, w_press, w_left;
  logic [WIN_W-1:0]     r_win_cnt, w_win_cnt_nx, w_cnt_tk;
  logic [SCORE_W-1:0]   r_score, w_score_nx;
  logic [SCORE_W:0]     w_add, w_sum;
  logic [COMBO_W-1:0]   r_combo, w_combo_nx;
  logic [MULT_W-1:0]    r_mult, w_mult_nx;
  logic [SUB_W-1:0]     r_sub_cnt, w_sub_nx;
  logic [LIVES_W-1:0]   r_lives, w_lives_nx;
  logic                 r_correct, r_incorrect, r_game_over;
  logic                 w_correct_nx, w_incorrect_nx, w_game_over_nx;
  logic                 w_wrong, w_complete, w_miss, w_arm;
`ifdef LANE_HIT_JUDGE_LIFE_REGEN_EN
  localparam int RG_W = $clog2(REGEN_COMBO + 1);
  localparam logic [RG_W-1:0] RG_LAST = RG_W'(REGEN_COMBO - 1);
  logic [RG_W-1:0] r_regen_cnt, w_regen_nx;
`endif

  btn_edge_detect #(.WIDTH(NUM_LANES)) u_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (bus.btn),
    .i_hold  (bus.pause),
    .o_rise  (w_press)
  );

  assign w_left   = r_pending & ~w_press;
  assign w_cnt_tk = r_win_cnt + WIN_W'(bus.tick);

  always_comb begin
    // NOTE: every next-state value gets a default first so no latch is inferred.
    w_state_nx     = r_state;
    w_pending_nx   = r_pending;
    w_win_cnt_nx   = r_win_cnt;
    w_score_nx     = r_score;
    w_combo_nx     = r_combo;
    w_mult_nx      = r_mult;
    w_sub_nx       = r_sub_cnt;
    w_lives_nx     = r_lives;
    w_game_over_nx = r_game_over;
    w_correct_nx   = 1'b0;
    w_incorrect_nx = 1'b0;
    w_wrong        = 1'b0;
    w_complete     = 1'b0;
    w_miss         = 1'b0;
    w_arm          = 1'b0;
    w_add          = '0;
    w_sum          = '0;
`ifdef LANE_HIT_JUDGE_LIFE_REGEN_EN
    w_regen_nx     = r_regen_cnt;
`endif

    if (!bus.pause) begin
      unique case (r_state)
        IDLE: begin
          w_wrong = |w_press;
          w_arm   = bus.beat && (|bus.arrow_mask);
        end
        OPEN: begin
          w_wrong      = |(w_press & ~r_pending);
          w_complete   = ~|w_left;
          w_miss       = !w_complete && (bus.beat || (w_cnt_tk == WIN_LAST));
          w_arm        = bus.beat && (|bus.arrow_mask);
          w_pending_nx = w_left;
          w_win_cnt_nx = w_cnt_tk;
          if (w_complete || w_miss) w_state_nx = IDLE;
        end
        default: ;
      endcase
    end

    // Breaking the streak first makes a simultaneous completion score at multiplier 1.
    if (w_wrong || w_miss) begin
      w_incorrect_nx = 1'b1;
      w_combo_nx     = '0;
      w_mult_nx      = MULT_W'(1);
      w_sub_nx       = '0;
`ifdef LANE_HIT_JUDGE_LIFE_REGEN_EN
      w_regen_nx     = '0;
`endif
    end

    if (w_complete) begin
      w_correct_nx = 1'b1;
      w_add        = ((r_win_cnt <= WIN_PERFECT) ? PTS_PERFECT : PTS_GOOD) * (SCORE_W+1)'(w_mult_nx);
      w_sum        = {1'b0, r_score} + w_add;
      w_score_nx   = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
      w_combo_nx   = (&w_combo_nx) ? w_combo_nx : w_combo_nx + COMBO_W'(1);
      if (w_sub_nx == SUB_LAST) begin
        w_sub_nx = '0;
        if (w_mult_nx != MULT_TOP) w_mult_nx = w_mult_nx + MULT_W'(1);
      end else begin
        w_sub_nx = w_sub_nx + SUB_W'(1);
      end
`ifdef LANE_HIT_JUDGE_LIFE_REGEN_EN
      if (w_regen_nx == RG_LAST) begin
        w_regen_nx = '0;
        if (r_lives != LIVES_FULL) w_lives_nx = r_lives + LIVES_W'(1);
      end else begin
        w_regen_nx = w_regen_nx + RG_W'(1);
      end
`endif
    end

    if (w_miss) begin
      w_lives_nx = r_lives - LIVES_W'(1);
      if (r_lives == LIVES_W'(1)) begin
        w_game_over_nx = 1'b1;
        w_state_nx     = OVER;
      end
    end

    if (w_arm && !w_game_over_nx) begin
      w_pending_nx = bus.arrow_mask;
      w_win_cnt_nx = '0;
      w_state_nx   = OPEN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_win_cnt   <= '0;
      r_score     <= '0;
      r_combo     <= '0;
      r_mult      <= MULT_W'(1);
      r_sub_cnt   <= '0;
      r_lives     <= LIVES_FULL;
      r_correct   <= 1'b0;
      r_incorrect <= 1'b0;
      r_game_over <= 1'b0;
`ifdef LANE_HIT_JUDGE_LIFE_REGEN_EN
      r_regen_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_pending   <= w_pending_nx;
      r_win_cnt   <= w_win_cnt_nx;
      r_score     <= w_score_nx;
      r_combo     <= w_combo_nx;
      r_mult      <= w_mult_nx;
      r_sub_cnt   <= w_sub_nx;
      r_lives     <= w_lives_nx;
      r_correct   <= w_correct_nx;
      r_incorrect <= w_incorrect_nx;
      r_game_over <= w_game_over_nx;
`ifdef LANE_HIT_JUDGE_LIFE_REGEN_EN
      r_regen_cnt <= w_regen_nx;
`endif
    end
  end

  assign bus.score         = r_score;
  assign bus.combo         = r_combo;
  assign bus.multiplier    = r_mult;
  assign bus.lives         = r_lives;
  assign bus.correct_hit   = r_correct;
  assign bus.incorrect_hit = r_incorrect;
  assign bus.game_over     = r_game_over;

endmodule

// File: doc/lane_hit_judge.md
Name: lane_hit_judge

Overview:
- Parametrised, multi-lane successor to the game's single-arrow hit/score path.
- Decides per beat whether the player hit every arrow lane present at the hit line within a tick-counted timing window.
- Maintains score, combo, multiplier and lives, and drives game-over.
- Sits between the arrow generator (beat pulse + lane mask) and the display/LED logic; runs on the system clock with pulse strobes from the clock module.

Parameters:
- NUM_LANES, 4, number of arrow lanes/buttons
- WINDOW_TICKS, 8, ticks after beat before pending arrows count as missed (>=2)
- PERFECT_TICKS, 3, ticks at or below which a completed hit scores as perfect (< WINDOW_TICKS)
- POINTS_PERFECT, 3, base points for a perfect hit
- POINTS_GOOD, 1, base points for a good hit
- COMBO_PER_MULT, 10, consecutive hits per multiplier step
- MULT_MAX, 8, multiplier ceiling (<=15)
- LIVES_INIT, 5, lives after reset (<=7)
- SCORE_W, 14, score width
- COMBO_W, 14, combo width

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- tick, in, 1, one-cycle timing-window strobe
- beat, in, 1, one-cycle strobe: arrow row reaches hit line
- arrow_mask, in, NUM_LANES, lanes holding an arrow at beat
- btn, in, NUM_LANES, synchronised/debounced button levels
- pause, in, 1, freeze game state
- score, out, SCORE_W, accumulated score
- combo, out, COMBO_W, consecutive successful beats
- multiplier, out, 4, current multiplier (1..MULT_MAX)
- lives, out, 3, remaining lives
- correct_hit, out, 1, one-cycle pulse on completed beat
- incorrect_hit, out, 1, one-cycle pulse on miss or wrong press
- game_over, out, 1, sticky once lives reach 0

Behaviour:
- Clocking and reset: one clock (clk). Synchronous active-high reset (reset), applied on the clk edge.
- Reset values: score=0, combo=0, multiplier=1, lives=LIVES_INIT, pulses=0, game_over=0, FSM=IDLE, pending=0, win_cnt=0, btn_q=btn (prevents a phantom edge).
- Press edge: btn & ~btn_q, registered one cycle. btn_q updates every cycle, including during pause.
- FSM states:
  - IDLE: no pending arrows.
  - OPEN: window running.
  - OVER: game over.
- IDLE, beat with arrow_mask!=0: pending<=arrow_mask, win_cnt<=0, go to OPEN. beat with mask 0 is ignored.
- IDLE, any press edge: wrong press.
- OPEN, each tick: win_cnt++.
- OPEN, press on a pending lane: clear that pending bit.
- OPEN, press on a non-pending lane: wrong press.
- OPEN, pending becomes 0 (completed):
  - score += base*multiplier, where base = POINTS_PERFECT if win_cnt<=PERFECT_TICKS, else POINTS_GOOD.
  - combo++; correct_hit pulse; go to IDLE.
- OPEN, win_cnt==WINDOW_TICKS with pending!=0 (miss): incorrect_hit pulse, combo=0, multiplier=1, lives--, go to IDLE.
- OPEN, beat while pending!=0: resolve as a miss, then arm the new mask in the same cycle (stay OPEN).
- Wrong press: incorrect_hit pulse, combo=0, multiplier=1, no life loss.
- Wrong press and completion in the same cycle: both pulse. The beat scores at multiplier 1 and combo becomes 1.
- Multiplier: tracked via a sub-counter, not division. Increments by 1 each time COMBO_PER_MULT consecutive hits accrue; saturates at MULT_MAX.
- Arithmetic: score saturates at 2^SCORE_W-1 and combo at 2^COMBO_W-1; neither wraps.
- Lives: a decrement that reaches 0 sets game_over and moves the FSM to OVER. In OVER all inputs are ignored and outputs hold until reset.
- Pause=1: FSM, counters, score and lives frozen; tick, beat and edges discarded; pulses held 0.
- Reset mid-window: discards pending arrows and restores all reset values.
- Latency: judgement outputs update one clk after the registered edge/tick/beat that causes them.

Optional Feature:
- Macro: LANE_HIT_JUDGE_LIFE_REGEN_EN.
- When defined: adds parameter REGEN_COMBO (default 25). Each time combo crosses a nonzero multiple of REGEN_COMBO, lives increments, saturating at LIVES_INIT. No regen in OVER.
- When undefined: lives only decrease. Behaviour is otherwise identical.

Decomposition:
- Shared package ddr_pkg:
  - FSM state enum (IDLE/OPEN/OVER).
  - Lives width constant (3) and multiplier width constant (4).
  - Lane index type sized by NUM_LANES.
- Sub-module btn_edge_detect: parametrised by width; registers levels and emits per-lane rising-edge pulses with a hold/pause input. Instantiated once.

Test Plan:
- Perfect hit: reset; beat with mask=4'b0101; press lanes 0 and 2 after 2 ticks -> correct_hit pulse; score=3, combo=1, multiplier=1.
- Miss: beat mask=4'b0010; no press for 8 ticks -> incorrect_hit pulse on the 8th tick; combo=0, lives=4.
- Multiplier ramp: 10 good hits -> multiplier=2; 11th hit (good) adds 2; score=12.
- Wrong lane: beat mask=4'b0001; press lane 3 -> incorrect_hit; combo=0; lives unchanged; window still open.
- Game over: 5 consecutive misses -> lives=0, game_over=1. Further beats/presses change nothing until reset, after which lives=5.
- Pause: press lane 0 while pause=1 in an open window, release, deassert pause -> no edge registered and win_cnt unchanged across pause. With LANE_HIT_JUDGE_LIFE_REGEN_EN, 25 hits after one miss restores lives to 5.
